// File: rtl/keypad_entry.sv
// Keypad entry front end: gathers three digit keys, submits them to the password
// checker, reports granted/denied and enforces a lockout after repeated failures.
module keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 5000,
    parameter int MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       unlock,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       lock_input,
    output logic [1:0] digit_count,
    output logic       granted,
    output logic       denied,
    output logic       locked_out
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    typedef enum logic [1:0] {ENTRY, SUBMIT, CHECK, LOCKOUT} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] idle_cnt, idle_nx;
    logic [LW-1:0] lock_cnt, lock_nx;
    logic [FW-1:0] fail_cnt, fail_nx, fail_inc;
    logic [3:0]    d1_nx, d2_nx, d3_nx;
    logic [1:0]    cnt_nx;
    logic          lock_input_nx, granted_nx, denied_nx, locked_nx;
    logic          digit_key;

    always_comb begin
        state_nx      = state;
        d1_nx         = digit1;
        d2_nx         = digit2;
        d3_nx         = digit3;
        cnt_nx        = digit_count;
        idle_nx       = idle_cnt;
        lock_nx       = lock_cnt;
        fail_nx       = fail_cnt;
        lock_input_nx = 1'b0;
        granted_nx    = 1'b0;
        denied_nx     = 1'b0;
        locked_nx     = locked_out;
        fail_inc      = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);
        // A fourth digit is not an accepted key, so it cannot hold off the timeout
        digit_key     = key_valid && (key_code <= 4'd9) && (digit_count != 2'd3);

        case (state)
            ENTRY: begin
                if (digit_key) begin
                    case (digit_count)
                        2'd0:    d1_nx = key_code;
                        2'd1:    d2_nx = key_code;
                        default: d3_nx = key_code;
                    endcase
                    cnt_nx  = digit_count + 2'd1;
                    idle_nx = '0;
                end else if (key_valid && key_code == 4'hC) begin
                    {d1_nx, d2_nx, d3_nx, cnt_nx} = '0;
                    idle_nx = '0;
                end else if (key_valid && key_code == 4'hE) begin
                    idle_nx = '0;
                    if (digit_count == 2'd3) begin
                        state_nx      = SUBMIT;
                        lock_input_nx = 1'b1;
                    end else begin
                        denied_nx = 1'b1;
                        {d1_nx, d2_nx, d3_nx, cnt_nx} = '0;
                    end
                end else if (digit_count != 2'd0) begin
                    if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        {d1_nx, d2_nx, d3_nx, cnt_nx} = '0;
                        idle_nx = '0;
                    end else begin
                        idle_nx = idle_cnt + TW'(1);
                    end
                end else begin
                    idle_nx = '0;
                end
            end
            SUBMIT: state_nx = CHECK;
            CHECK: begin
                {d1_nx, d2_nx, d3_nx, cnt_nx} = '0;
                state_nx = ENTRY;
                if (unlock) begin
                    granted_nx = 1'b1;
                    fail_nx    = '0;
                end else begin
                    denied_nx = 1'b1;
                    fail_nx   = fail_inc;
                    if (fail_inc == FW'(MAX_FAILS)) begin
                        state_nx  = LOCKOUT;
                        locked_nx = 1'b1;
                        lock_nx   = LW'(LOCKOUT_CYCLES);
                    end
                end
            end
            LOCKOUT: begin
                // Counter is loaded with the full length, so the final lockout cycle sees 1
                if (lock_cnt <= LW'(1)) begin
                    lock_nx   = '0;
                    locked_nx = 1'b0;
                    fail_nx   = '0;
                    state_nx  = ENTRY;
                end else begin
                    lock_nx = lock_cnt - LW'(1);
                end
            end
            default: state_nx = ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ENTRY;
            digit1      <= '0;
            digit2      <= '0;
            digit3      <= '0;
            digit_count <= '0;
            idle_cnt    <= '0;
            lock_cnt    <= '0;
            fail_cnt    <= '0;
            lock_input  <= 1'b0;
            granted     <= 1'b0;
            denied      <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            state       <= state_nx;
            digit1      <= d1_nx;
            digit2      <= d2_nx;
            digit3      <= d3_nx;
            digit_count <= cnt_nx;
            idle_cnt    <= idle_nx;
            lock_cnt    <= lock_nx;
            fail_cnt    <= fail_nx;
            lock_input  <= lock_input_nx;
            granted     <= granted_nx;
            denied      <= denied_nx;
            locked_out  <= locked_nx;
        end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios then random keys, checked every cycle
// against a time-stamped entry model and an attached checker accepting 123 and 234.
module tb_keypad_entry;
    localparam int TO = 20;
    localparam int LO = 30;
    localparam int MF = 3;

    logic       clk = 1'b0;
    logic       rst, key_valid, unlock;
    logic [3:0] key_code;
    logic [3:0] digit1, digit2, digit3;
    logic [1:0] digit_count;
    logic       lock_input, granted, denied, locked_out;

    keypad_entry #(.TIMEOUT_CYCLES(TO), .LOCKOUT_CYCLES(LO), .MAX_FAILS(MF)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .unlock(unlock),
        .digit1(digit1), .digit2(digit2), .digit3(digit3), .lock_input(lock_input),
        .digit_count(digit_count), .granted(granted), .denied(denied), .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    // Password checker: answers in the cycle after the submit pulse
    always @(posedge clk) begin
        if (rst) unlock <= 1'b0;
        else unlock <= lock_input && ({digit1, digit2, digit3} == 12'h123 ||
                                      {digit1, digit2, digit3} == 12'h234);
    end

    int ent[$];
    int fails, pend, res_edge, lock_end, last_acc, e;
    bit m_lock, m_gr, m_dn;
    int n_cmp = 0;
    int n_err = 0;

    task automatic model_edge(input bit r, input bit kv, input logic [3:0] kc);
        int code;
        bit acc;
        m_lock = 0; m_gr = 0; m_dn = 0;
        if (r) begin
            ent.delete(); fails = 0; pend = -1; lock_end = 0; res_edge = e + 1;
            return;
        end
        if (pend >= 0) begin
            if (e == pend + 2) begin
                code = ent[0] * 100 + ent[1] * 10 + ent[2];
                res_edge = e + 1;
                if (code == 123 || code == 234) begin
                    m_gr = 1; fails = 0;
                end else begin
                    m_dn = 1; fails++;
                    if (fails == MF) begin
                        lock_end = e + LO; res_edge = e + LO + 1; fails = 0;
                    end
                end
                ent.delete(); pend = -1;
            end
        end else if (e >= res_edge) begin
            acc = 0;
            if (kv && kc <= 4'd9 && ent.size() < 3) begin
                ent.push_back(int'(kc)); acc = 1;
            end else if (kv && kc == 4'hC) begin
                ent.delete(); acc = 1;
            end else if (kv && kc == 4'hE) begin
                acc = 1;
                if (ent.size() == 3) begin pend = e; m_lock = 1; end
                else begin m_dn = 1; ent.delete(); end
            end
            if (acc) last_acc = e;
            else if (ent.size() > 0 && e - last_acc == TO) ent.delete();
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_digit(input int i);
        return (i < ent.size()) ? 4'(ent[i]) : 4'd0;
    endfunction

    task automatic tick(input bit r, input bit kv, input logic [3:0] kc);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_edge(r, kv, kc);
        #1;
        check("digit1", digit1, exp_digit(0));
        check("digit2", digit2, exp_digit(1));
        check("digit3", digit3, exp_digit(2));
        check("digit_count", {2'b0, digit_count}, 4'(ent.size()));
        check("lock_input", {3'b0, lock_input}, {3'b0, m_lock});
        check("granted", {3'b0, granted}, {3'b0, m_gr});
        check("denied", {3'b0, denied}, {3'b0, m_dn});
        check("locked_out", {3'b0, locked_out}, {3'b0, e < lock_end});
        e++;
    endtask

    task automatic press(input logic [3:0] k);
        tick(0, 1, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 4'h0);
    endtask

    initial begin
        e = 0; fails = 0; pend = -1; res_edge = 0; lock_end = 0; last_acc = 0;
        rst = 1; key_valid = 0; key_code = 0;
        tick(1, 0, 0);
        tick(1, 0, 0);
        idle(2);
        // correct code
        press(1); press(2); press(3); press(4'hE); idle(4);
        // three wrong codes, keys during lockout, then recovery
        for (int n = 0; n < 3; n++) begin
            press(9); press(9); press(9); press(4'hE); idle(3);
        end
        press(1); press(2); press(3); press(4'hE);
        idle(LO);
        press(2); press(3); press(4); press(4'hE); idle(4);
        // short entry, then an ignored fourth digit
        press(1); press(2); press(4'hE); idle(2);
        press(1); press(2); press(3); press(4); press(4'hE); idle(4);
        // timeout, and a key landing on the expiry edge
        press(5); press(6); idle(TO + 3);
        press(5); press(6); idle(TO - 1); press(7); idle(TO + 2);
        // clear then correct code; unknown codes ignored
        press(2); press(4'hC); press(4'hA); press(1); press(2); press(3); press(4'hE); idle(4);
        // reset during the submit cycle
        press(1); press(2); press(3); press(4'hE); tick(1, 0, 0); idle(4);
        // random keys with random gaps
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [3:0] k;
            r = int'($urandom_range(0, 99));
            if (r < 55) k = 4'($urandom_range(1, 4));
            else if (r < 72) k = 4'hE;
            else if (r < 78) k = 4'hC;
            else k = 4'($urandom_range(0, 15));
            tick($urandom_range(0, 199) == 0, 1, k);
            r = int'($urandom_range(0, 29));
            if (r == 0) idle(TO - 1 + int'($urandom_range(0, 2)));
            else idle(r % 4);
        end
        idle(LO + 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
